// File: rtl/muxn_rr_if.sv
// muxn_rr_if: producer/consumer bundle for the muxn_rr channel mux.
// Ports: i/iv/ir per-channel data, valid and ready; s/md channel select
//        and mode; ot/ov/och registered output word, valid and channel id;
//        od downstream ready. master = producers+consumer, slave = mux.
interface muxn_rr_if #(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] i;
  logic [N-1:0]   iv;
  logic [N-1:0]   ir;
  logic [SW-1:0]  s;
  logic           md;
  logic [W-1:0]   ot;
  logic           ov;
  logic           od;
  logic [SW-1:0]  och;

  modport master (
    output i, iv, s, md, od,
    input  ir, ot, ov, och
  );

  modport slave (
    input  i, iv, s, md, od,
    output ir, ot, ov, och
  );
endinterface

// File: rtl/muxn_rr.sv
// muxn_rr: N-channel W-bit registered mux with valid/ready handshake,
// fixed-select (md=0) or round-robin (md=1) channel choice.
// Ports: clk, rst (sync, active-high); bus (muxn_rr_if.slave):
//   i/iv/ir input side, s/md selection, ot/ov/och/od output slot.
module muxn_rr #(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input logic      clk,
  input logic      rst,
  muxn_rr_if.slave bus
);

  logic [W-1:0]  ot_q, ot_d;
  logic          ov_q, ov_d;
  logic [SW-1:0] och_q, och_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          fx_hit;
  logic          rr_hit;
  logic [SW-1:0] rr_ch;
  logic          c_hit;
  logic [SW-1:0] c_ch;
  logic          grant;
  logic [N-1:0]  gnt_oh;
  logic [SW-1:0] rr_ord [N];

  // Slot can take a word when empty or draining this cycle.
  assign load = !ov_q || bus.od;

  // s may exceed N-1 when N is not a power of two.
  assign fx_hit = (32'(bus.s) < N) && bus.iv[bus.s];

  // Scan order ptr+1 .. ptr+N, wrapped modulo N.
  // ptr never exceeds N-1, so one subtraction wraps.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (32'(ptr_q) + 32'(k) + 32'd1 >= 32'(N)) begin
        rr_ord[k] = SW'(32'(ptr_q) + 32'(k) + 32'd1 - 32'(N));
      end else begin
        rr_ord[k] = SW'(32'(ptr_q) + 32'(k) + 32'd1);
      end
    end
  end

  // Walk backwards so the earliest scan slot wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_ch  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.iv[rr_ord[k]]) begin
        rr_hit = 1'b1;
        rr_ch  = rr_ord[k];
      end
    end
  end

  always_comb begin
    c_hit = fx_hit;
    c_ch  = bus.s;
    unique case (1'b1)
      bus.md: begin
        c_hit = rr_hit;
        c_ch  = rr_ch;
      end
      default: begin
        c_hit = fx_hit;
        c_ch  = bus.s;
      end
    endcase
  end

  assign grant = c_hit && load && !rst;

  always_comb begin
    gnt_oh = '0;
    if (grant) gnt_oh[c_ch] = 1'b1;
  end

  assign bus.ir = gnt_oh;

  always_comb begin
    ot_d  = ot_q;
    ov_d  = ov_q;
    och_d = och_q;
    ptr_d = ptr_q;
    if (load) ov_d = grant;
    if (grant) begin
      ot_d  = bus.i[c_ch*W +: W];
      och_d = c_ch;
      if (bus.md) ptr_d = c_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ot_q  <= '0;
      ov_q  <= 1'b0;
      och_q <= '0;
      ptr_q <= SW'(N - 1);
    end else begin
      ot_q  <= ot_d;
      ov_q  <= ov_d;
      och_q <= och_d;
      ptr_q <= ptr_d;
    end
  end

  assign bus.ot  = ot_q;
  assign bus.ov  = ov_q;
  assign bus.och = och_q;

endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: table vectors, hand sequences and random traffic
// against a behavioural model of the N-channel mux.
module tb_muxn_rr;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muxn_rr_if #(.W(W), .N(N)) bus ();

  muxn_rr #(.W(W), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  logic         m_ov;
  logic [W-1:0] m_ot;
  int           m_och;
  int           m_ptr;
  logic [N-1:0] last_ir;

  typedef struct {
    logic          r;
    logic [N*W-1:0] i;
    logic [N-1:0]  iv;
    logic [SW-1:0] s;
    logic          md;
    logic          od;
    logic [N-1:0]  x_ir;
    logic          x_ov;
    logic [W-1:0]  x_ot;
    logic [SW-1:0] x_och;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (rst) return -1;
    if (m_ov && !bus.od) return -1;
    if (!bus.md) begin
      if (int'(bus.s) < N && bus.iv[bus.s]) return int'(bus.s);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.iv[c]) return c;
    end
    return -1;
  endfunction

  task automatic cyc(input logic r, input logic [N*W-1:0] i,
                     input logic [N-1:0] iv, input logic [SW-1:0] s,
                     input logic md, input logic od);
    int g;
    logic [N-1:0] xir;
    @(negedge clk);
    rst    = r;
    bus.i  = i;
    bus.iv = iv;
    bus.s  = s;
    bus.md = md;
    bus.od = od;
    #1;
    g = exp_grant();
    xir = '0;
    if (g >= 0) xir[g] = 1'b1;
    last_ir = bus.ir;
    chk("m.ir", 32'(bus.ir), 32'(xir));
    chk("m.ir1hot", 32'($countones(bus.ir) <= 1), 32'd1);
    chk("m.ov", 32'(bus.ov), 32'(m_ov));
    if (m_ov) begin
      chk("m.ot", 32'(bus.ot), 32'(m_ot));
      chk("m.och", 32'(bus.och), 32'(m_och));
    end
    @(posedge clk);
    if (r) begin
      m_ov = 1'b0; m_ot = '0; m_och = 0; m_ptr = N - 1;
    end else if (!m_ov || od) begin
      if (g >= 0) begin
        m_ov  = 1'b1;
        m_ot  = i[g*W +: W];
        m_och = g;
        if (md) m_ptr = g;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic post(input string nm, input logic xov,
                      input logic [W-1:0] xot, input logic [SW-1:0] xoch);
    #1;
    chk({nm, ".ov"}, 32'(bus.ov), 32'(xov));
    chk({nm, ".ot"}, 32'(bus.ot), 32'(xot));
    chk({nm, ".och"}, 32'(bus.och), 32'(xoch));
  endtask

  task automatic add(input logic r, input logic [N*W-1:0] i,
                     input logic [N-1:0] iv, input logic [SW-1:0] s,
                     input logic md, input logic od, input logic [N-1:0] xir,
                     input logic xov, input logic [W-1:0] xot,
                     input logic [SW-1:0] xoch);
    vec_t v;
    v.r = r; v.i = i; v.iv = iv; v.s = s; v.md = md; v.od = od;
    v.x_ir = xir; v.x_ov = xov; v.x_ot = xot; v.x_och = xoch;
    tbl.push_back(v);
  endtask

  localparam logic [N*W-1:0] DCBA = 16'hDCBA;

  initial begin
    rst = 1'b1;
    bus.i = '0; bus.iv = '0; bus.s = '0; bus.md = 1'b0; bus.od = 1'b0;
    m_ov = 1'b0; m_ot = '0; m_och = 0; m_ptr = N - 1;
    last_ir = '0;
    repeat (2) @(posedge clk);

    // reset with all valid, then RR fairness
    add(1, DCBA, 4'hF, 0, 1, 1, 4'b0000, 0, 4'h0, 0);
    add(1, DCBA, 4'hF, 0, 1, 1, 4'b0000, 0, 4'h0, 0);
    for (int k = 0; k < 8; k++)
      add(0, DCBA, 4'hF, 0, 1, 1, 4'(1 << (k % 4)), 1,
          4'(4'hA + k % 4), 2'(k % 4));
    // fixed mode stepping, invalid select, slot hold
    add(0, DCBA, 4'hF, 0, 0, 1, 4'b0001, 1, 4'hA, 0);
    add(0, DCBA, 4'hF, 1, 0, 1, 4'b0010, 1, 4'hB, 1);
    add(0, DCBA, 4'hF, 2, 0, 1, 4'b0100, 1, 4'hC, 2);
    add(0, DCBA, 4'hF, 3, 0, 1, 4'b1000, 1, 4'hD, 3);
    add(0, DCBA, 4'hB, 2, 0, 1, 4'b0000, 0, 4'hD, 3);
    add(0, DCBA, 4'hF, 0, 0, 0, 4'b0001, 1, 4'hA, 0);
    add(0, DCBA, 4'hF, 1, 0, 0, 4'b0000, 1, 4'hA, 0);
    add(0, DCBA, 4'hF, 1, 0, 1, 4'b0010, 1, 4'hB, 1);
    // RR skip and wrap
    add(1, DCBA, 4'hF, 0, 1, 1, 4'b0000, 0, 4'h0, 0);
    add(0, DCBA, 4'hA, 0, 1, 1, 4'b0010, 1, 4'hB, 1);
    add(0, DCBA, 4'hA, 0, 1, 1, 4'b1000, 1, 4'hD, 3);
    add(0, DCBA, 4'hA, 0, 1, 1, 4'b0010, 1, 4'hB, 1);
    add(0, DCBA, 4'h1, 0, 1, 1, 4'b0001, 1, 4'hA, 0);
    add(0, DCBA, 4'h0, 0, 1, 1, 4'b0000, 0, 4'hA, 0);

    foreach (tbl[n]) begin
      cyc(tbl[n].r, tbl[n].i, tbl[n].iv, tbl[n].s, tbl[n].md, tbl[n].od);
      chk($sformatf("t%0d.ir", n), 32'(last_ir), 32'(tbl[n].x_ir));
      post($sformatf("t%0d", n), tbl[n].x_ov, tbl[n].x_ot, tbl[n].x_och);
    end

    // backpressure then same-cycle pass-through
    cyc(1, '0, '0, 0, 0, 1);
    cyc(0, 16'h0700, 4'b0100, 2, 0, 1);
    post("bp.load", 1, 4'h7, 2);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 16'hFFFF, 4'hF, 2'(k), 1'(k), 0);
      chk("bp.ir", 32'(last_ir), 32'd0);
      post("bp.hold", 1, 4'h7, 2);
    end
    cyc(0, 16'h0090, 4'b0010, 1, 0, 1);
    chk("pt.ir", 32'(last_ir), 32'b0010);
    post("pt", 1, 4'h9, 1);

    // reset while a word is held
    cyc(0, 16'h0005, 4'b0001, 0, 0, 1);
    post("mr.load", 1, 4'h5, 0);
    cyc(0, 16'h0005, 4'hF, 0, 0, 0);
    post("mr.hold", 1, 4'h5, 0);
    cyc(1, 16'h0005, 4'hF, 0, 1, 0);
    chk("mr.rst.ir", 32'(last_ir), 32'd0);
    post("mr.rst", 0, 4'h0, 0);
    cyc(0, 16'h0005, 4'hF, 0, 1, 1);
    chk("mr.ir", 32'(last_ir), 32'b0001);
    post("mr.rr", 1, 4'h5, 0);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 24) == 0), 16'($urandom),
          4'($urandom), 2'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
